// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared fetch-stage types, MIPS opcode/field constants and helpers.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_DROP
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [5:0]  OP_J      = 6'b000010;
  localparam logic [5:0]  OP_BEQ    = 6'b000100;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int TGT_HI = 25;
  localparam int TGT_LO = 0;

  // j target: upper nibble of the delay-slot PC, 26-bit word index, byte offset 0
  function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [31:0] instr);
    return {pc4[31:28], instr[TGT_HI:TGT_LO], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg: IF/ID pipeline register; flush beats load, hold blocks load.
module ifid_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        take;

  assign take = load_i & ~hold_i;

  always_comb begin
    valid_d = flush_i ? 1'b0      : take ? 1'b1    : valid_q;
    instr_d = flush_i ? NOP_INSTR : take ? instr_i : instr_q;
    pc4_d   = flush_i ? 32'h0     : take ? pc4_i   : pc4_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with variable-latency imem, one-entry
// stall hold buffer and single-bubble branch/jump redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic [31:0]  hb_instr_q, hb_instr_d;
  logic [31:0]  hb_pc4_q, hb_pc4_d;
  logic [31:0]  pc4, target_raw, target, ld_instr, ld_pc4;
  logic         redirect, ld;

  assign pc4        = pc_q + 32'd4;
  assign redirect   = (state_q != ST_IDLE) && (branch_taken_i || (jump_i && ifid_valid_o));
  assign target_raw = branch_taken_i ? branch_target_i : jump_target(ifid_pc4_o, ifid_instr_o);
  assign target     = {target_raw[31:2], 2'b00};
  assign ld_instr   = (state_q == ST_HOLD) ? hb_instr_q : imem_rdata_i;
  assign ld_pc4     = (state_q == ST_HOLD) ? hb_pc4_q : pc4;

  assign imem_req_o  = (state_q == ST_REQ) || (state_q == ST_DROP);
  assign imem_addr_o = (state_q == ST_DROP) ? drop_addr_q : pc_q;
  assign pc_o        = pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = redirect ? target : pc_q;
    drop_addr_d = drop_addr_q;
    hb_instr_d  = hb_instr_q;
    hb_pc4_d    = hb_pc4_q;
    ld          = 1'b0;
    case (state_q)
      ST_IDLE: state_d = start_i ? ST_REQ : ST_IDLE;
      ST_REQ: begin
        if (redirect) begin
          // outstanding request must still complete, so remember its address
          state_d     = imem_ready_i ? ST_REQ : ST_DROP;
          drop_addr_d = pc_q;
        end else if (imem_ready_i) begin
          pc_d = pc4;
          ld   = 1'b1;
          if (stall_i) begin
            hb_instr_d = imem_rdata_i;
            hb_pc4_d   = pc4;
            state_d    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_REQ;
        end else if (!stall_i) begin
          ld      = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_DROP: state_d = imem_ready_i ? ST_REQ : ST_DROP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      hb_instr_q  <= NOP_INSTR;
      hb_pc4_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      hb_instr_q  <= hb_instr_d;
      hb_pc4_q    <= hb_pc4_d;
    end
  end

  ifid_reg u_ifid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (ld),
    .hold_i  (stall_i),
    .flush_i (redirect),
    .instr_i (ld_instr),
    .pc4_i   (ld_pc4),
    .valid_o (ifid_valid_o),
    .instr_o (ifid_instr_o),
    .pc4_o   (ifid_pc4_o)
  );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core, directly upstream of the opcode decoder. Holds the PC, issues word requests to a variable-latency instruction memory, and loads the IF/ID pipeline register whose `instr[31:26]` drives the decoder's opcode input. Absorbs decode-stage stalls with a one-entry hold buffer and applies branch/jump redirects with a one-slot flush.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  leave IDLE and begin fetching; sampled only in IDLE.
- `stall_i`  in  1  ID stage cannot accept (load-use); hold IF/ID.
- `branch_taken_i`  in  1  beq resolved taken in ID this cycle.
- `branch_target_i`  in  32  branch destination byte address.
- `jump_i`  in  1  ID holds a j instruction.
- `imem_req_o`  out  1  read request; held until accepted.
- `imem_addr_o`  out  32  word-aligned fetch address; stable while `imem_req_o`.
- `imem_ready_i`  in  1  read data valid; completes the request this cycle.
- `imem_rdata_i`  in  32  instruction word.
- `pc_o`  out  32  current fetch PC.
- `ifid_valid_o`  out  1  IF/ID holds a real instruction.
- `ifid_instr_o`  out  32  instruction to decoder.
- `ifid_pc4_o`  out  32  address of that instruction + 4.

## Operation
- States: IDLE, REQ, HOLD, DROP.
- IDLE: `imem_req_o`=0. `start_i`=1 -> REQ.
- REQ: `imem_req_o`=1, `imem_addr_o`=`pc_o`. On `imem_ready_i` with no redirect: if `stall_i`=0, IF/ID <= {valid=1, rdata, pc+4}, PC <= PC+4, stay REQ; if `stall_i`=1, rdata and pc+4 go to hold buffer, PC <= PC+4, -> HOLD.
- HOLD: `imem_req_o`=0. IF/ID frozen. When `stall_i`=0: IF/ID <= hold buffer, -> REQ.
- Redirect = `branch_taken_i` or (`jump_i` and `ifid_valid_o`). Target: branch_target_i if `branch_taken_i`, else jump target = {ifid_pc4_o[31:28], ifid_instr_o[25:0], 2'b00}. Branch wins if both.
- On redirect, any state except IDLE: PC <= target; IF/ID flushed (valid=0, instr=32'h0, pc4=0); hold buffer discarded. From REQ with ready=0 -> DROP; all other cases -> REQ.
- DROP: `imem_req_o`=1 with the stale address (no request withdrawn mid-handshake); on `imem_ready_i`, data discarded -> REQ at new PC. A second redirect in DROP only updates PC.
- Redirect overrides `stall_i` in the same cycle.
- `stall_i` while REQ with ready=0: no effect; IF/ID already holds.
- PC arithmetic mod 2^32; PC+4 at 32'hFFFF_FFFC wraps to 0. `imem_addr_o[1:0]` always 2'b00; target bits [1:0] ignored.

## Timing
- Reset (async assert, sync to state on deassert): state IDLE, `pc_o`=RESET_PC, `imem_req_o`=0, `imem_addr_o`=RESET_PC, `ifid_valid_o`=0, `ifid_instr_o`=0, `ifid_pc4_o`=0. Reset mid-request abandons it; memory must accept this.
- Zero-wait memory (ready same cycle as req): one instruction per cycle, IF/ID updated the edge after ready.
- Start to first valid IF/ID: 1 cycle + memory latency.
- Redirect costs one bubble (the flushed slot) plus any DROP wait.
- HOLD -> REQ: new request issued the cycle after `stall_i` falls.

## Structure
- Shared package: fetch state enum, `NOP_INSTR`=32'h0, `OP_J`=6'b000010 and `OP_BEQ`=6'b000100 (shared with the decoder), instruction field slice constants.
- Sub-module `ifid_reg`: valid/instr/pc4 register with load, hold and flush inputs; flush dominates load.

## Test plan
- Zero-wait memory, start at 0 -> `imem_addr_o` 0,4,8,12 on consecutive cycles; IF/ID pc4 4,8,12 one cycle behind.
- Ready after 3 cycles -> address 0 held 3 cycles, IF/ID loads once, no duplicate or skipped PC.
- Stall for 2 cycles when word at 8 returns -> HOLD, IF/ID keeps word 4, word 8 appears after stall drops, next request at 12.
- `branch_taken_i` with target 0x40 while fetch of 0x10 outstanding (ready=0) -> flush, DROP until ready, then request at 0x40; stale word never reaches IF/ID.
- IF/ID = j 0x100 at pc4 0x1000_0008, `jump_i`=1 -> next request 0x1000_0400, one bubble.
- Assert `rst_i` low mid-HOLD -> all outputs reset values immediately; no request until `start_i`.
